wb_port_arbiter: RTL

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Two-requester (ALU / LSU) writeback port arbiter with registered register-file write port.
// Optional macro WB_ARB_ROUND_ROBIN_EN selects round-robin conflict resolution instead of fixed LSU priority.
module wb_port_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_a_valid,
    input  logic [31:0] req_a_data,
    input  logic [4:0]  req_a_rd,
    output logic        req_a_ready,
    input  logic        req_b_valid,
    input  logic [31:0] req_b_data,
    input  logic [4:0]  req_b_rd,
    output logic        req_b_ready,
    input  logic        wb_stall,
    output logic        mux_sel,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [15:0] conflict_cnt
);

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_t;

    prio_t       state;
    prio_t       state_next;
    logic        grant_a;
    logic        grant_b;
    logic        xfer;
    logic [4:0]  xfer_rd;
    logic [31:0] xfer_data;
    logic        conflict;

    // Grant decode, transfer mux and next arbitration state
    always_comb begin
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        xfer_rd    = 5'd0;
        xfer_data  = 32'd0;
        state_next = state;
        conflict   = req_a_valid & req_b_valid;

        if (!reset && !wb_stall) begin
            grant_a = req_a_valid & (!req_b_valid | (state == PRIO_A));
            grant_b = req_b_valid & (!req_a_valid | (state == PRIO_B));
        end else begin
            grant_a = 1'b0;
            grant_b = 1'b0;
        end

        if (grant_b) begin
            xfer_rd   = req_b_rd;
            xfer_data = req_b_data;
        end else begin
            xfer_rd   = req_a_rd;
            xfer_data = req_a_data;
        end

`ifdef WB_ARB_ROUND_ROBIN_EN
        if (grant_a) begin
            state_next = PRIO_B;
        end else if (grant_b) begin
            state_next = PRIO_A;
        end else begin
            state_next = state;
        end
`else
        // Fixed mode: LSU owns conflicts from the first clock after reset onward
        state_next = PRIO_B;
`endif
    end

    assign xfer        = grant_a | grant_b;
    assign req_a_ready = grant_a;
    assign req_b_ready = grant_b;

    // Arbitration state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= PRIO_A;
        end else begin
            state <= state_next;
        end
    end

    // Writeback port: rd = 0 transfers complete but never write, and do not disturb wb_rd/wb_data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mux_sel <= 1'b0;
            wb_en   <= 1'b0;
            wb_rd   <= 5'd0;
            wb_data <= 32'd0;
        end else begin
            wb_en <= xfer & (xfer_rd != 5'd0);
            if (xfer) begin
                mux_sel <= grant_b;
            end
            if (xfer && (xfer_rd != 5'd0)) begin
                wb_rd   <= xfer_rd;
                wb_data <= xfer_data;
            end
        end
    end

    // Saturating conflict counter, counts even while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt <= 16'd0;
        end else if (conflict && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule
